// File: rtl/adc_min_readout_pkg.sv
// ---------------------------------------------------------------------------
// adc_min_readout_pkg
// Shared definitions for the ADC minimum readout block: read-port widths,
// register address offsets, status word bit positions, hysteresis counter
// width and the capture FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package adc_min_readout_pkg;

    localparam int RD_DATA_W   = 16;
    localparam int RD_ADDR_W   = 4;
    localparam int FRAME_CNT_W = 16;
    localparam int ALARM_CNT_W = 4;

    // Register addresses above the per-core snapshot slots, relative to CORE_NUM
    localparam int ADDR_OFS_STATUS = 0;
    localparam int ADDR_OFS_FRAME  = 1;

    // Status word layout
    localparam int STAT_VALID_BIT   = 0;
    localparam int STAT_OVERRUN_BIT = 1;
    localparam int STAT_ALARM_LSB   = 2;

    typedef enum logic [1:0] {
        CAP_IDLE  = 2'd0,
        CAP_WAIT  = 2'd1,
        CAP_LATCH = 2'd2
    } cap_state_e;

endpackage

// File: rtl/adc_min_alarm_filter.sv
// ---------------------------------------------------------------------------
// adc_min_alarm_filter
// Per-core low-level alarm with consecutive-frame hysteresis. While the
// alarm is clear, ALARM_COUNT consecutive low frames set it; while it is set,
// ALARM_COUNT consecutive high frames clear it. Any frame that agrees with
// the current alarm state zeroes the run counter.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   frame_en  in   one-cycle strobe: evaluate min_i as a new frame
//   min_i     in   captured per-core minimum
//   alarm_o   out  filtered alarm flag
// ---------------------------------------------------------------------------
module adc_min_alarm_filter
    import adc_min_readout_pkg::*;
#(
    parameter int ADC_DATA_WIDTH = 8,
    parameter int LOW_THRESH     = 8,
    parameter int ALARM_COUNT    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_en,
    input  logic [ADC_DATA_WIDTH-1:0] min_i,
    output logic                      alarm_o
);

    // One extra bit so a threshold of 2**W (every value low) still fits
    localparam logic [ADC_DATA_WIDTH:0]  THRESH_V = (ADC_DATA_WIDTH+1)'(LOW_THRESH);
    localparam logic [ALARM_CNT_W-1:0]   COUNT_V  = ALARM_CNT_W'(ALARM_COUNT);

    logic [ALARM_CNT_W-1:0] cnt_q, cnt_d;
    logic                   alarm_q, alarm_d;
    logic                   is_low;
    logic                   toward_flip;

    always_comb begin
        is_low      = ({1'b0, min_i} < THRESH_V);
        // A frame counts only if it disagrees with the current alarm state
        toward_flip = alarm_q ? ~is_low : is_low;
        cnt_d       = cnt_q;
        alarm_d     = alarm_q;
        if (frame_en) begin
            if (!toward_flip) begin
                cnt_d = '0;
            end else if (cnt_q + ALARM_CNT_W'(1) == COUNT_V) begin
                cnt_d   = '0;
                alarm_d = ~alarm_q;
            end else begin
                cnt_d = cnt_q + ALARM_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm_o = alarm_q;

endmodule

// File: rtl/adc_min_readout.sv
// ---------------------------------------------------------------------------
// adc_min_readout
// Captures each core's final minimum once per ms frame, CAPTURE_DELAY cycles
// after ms_tick so the detector pipeline has settled, runs the per-core alarm
// filters, and exposes snapshot, frame counter and status through a
// one-cycle-latency request/acknowledge read port.
//
// Capture FSM:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   CAP_IDLE  | waiting for ms_tick
//   CAP_WAIT  | delay counter running down toward the settled point
//   CAP_LATCH | commit snapshot / frame_cnt / filters (skipped on frame 0)
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   ms_tick    in   frame pulse, same cycle the detectors reload
//   adc_min_i  in   packed per-core minima, core k at [(k+1)*W-1 : k*W]
//   rd_req     in   one-cycle read strobe
//   rd_addr    in   read address
//   rd_ack     out  one-cycle acknowledge, one cycle after rd_req
//   rd_data    out  read data, held between acknowledges
//   alarm_o    out  filtered low-level alarm per core
// ---------------------------------------------------------------------------
module adc_min_readout
    import adc_min_readout_pkg::*;
#(
    parameter int ADC_DATA_WIDTH = 8,
    parameter int CORE_NUM       = 4,
    parameter int CAPTURE_DELAY  = 4,
    parameter int LOW_THRESH     = 8,
    parameter int ALARM_COUNT    = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ms_tick,
    input  logic [ADC_DATA_WIDTH*CORE_NUM-1:0] adc_min_i,
    input  logic                               rd_req,
    input  logic [RD_ADDR_W-1:0]               rd_addr,
    output logic                               rd_ack,
    output logic [RD_DATA_W-1:0]               rd_data,
    output logic [CORE_NUM-1:0]                alarm_o
);

    localparam int DLY_W = (CAPTURE_DELAY > 2) ? $clog2(CAPTURE_DELAY) : 1;
    localparam logic [RD_ADDR_W-1:0] ADDR_STATUS = RD_ADDR_W'(CORE_NUM + ADDR_OFS_STATUS);
    localparam logic [RD_ADDR_W-1:0] ADDR_FRAME  = RD_ADDR_W'(CORE_NUM + ADDR_OFS_FRAME);

    cap_state_e                state_q, state_d;
    logic [DLY_W-1:0]          dly_q, dly_d;

    logic                      latch_en;
    logic                      commit;
    logic                      overrun_set;

    logic [ADC_DATA_WIDTH-1:0] snap_q [CORE_NUM];
    logic [FRAME_CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                      primed_q;
    logic                      valid_q;
    logic                      overrun_q, overrun_d;
    logic                      stat_rd;

    logic                      rd_ack_q;
    logic [RD_DATA_W-1:0]      rd_data_q;
    logic [RD_DATA_W-1:0]      rd_mux;
    logic [RD_DATA_W-1:0]      status_word;
    logic [CORE_NUM-1:0]       alarm_w;

    // ---------------- capture FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CAP_IDLE;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
        end
    end

    // ---------------- capture FSM: next state ----------------
    // WAIT lasts CAPTURE_DELAY-1 cycles so LATCH lands on cycle T+CAPTURE_DELAY.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        unique case (state_q)
            CAP_IDLE: begin
                if (ms_tick) begin
                    if (CAPTURE_DELAY <= 1) begin
                        state_d = CAP_LATCH;
                    end else begin
                        dly_d   = DLY_W'(CAPTURE_DELAY - 1);
                        state_d = CAP_WAIT;
                    end
                end
            end
            CAP_WAIT: begin
                dly_d = dly_q - DLY_W'(1);
                if (dly_q == DLY_W'(1)) begin
                    state_d = CAP_LATCH;
                end
            end
            CAP_LATCH: state_d = CAP_IDLE;
            default:   state_d = CAP_IDLE;
        endcase
    end

    // ---------------- capture FSM: outputs ----------------
    always_comb begin
        latch_en    = (state_q == CAP_LATCH);
        // The first LATCH after reset covers a partial frame and is dropped
        commit      = latch_en & primed_q;
        overrun_set = ms_tick & (state_q != CAP_IDLE);
    end

    // ---------------- alarm filters ----------------
    for (genvar k = 0; k < CORE_NUM; k++) begin : g_filt
        adc_min_alarm_filter #(
            .ADC_DATA_WIDTH (ADC_DATA_WIDTH),
            .LOW_THRESH     (LOW_THRESH),
            .ALARM_COUNT    (ALARM_COUNT)
        ) u_filt (
            .clk      (clk),
            .rst      (rst),
            .frame_en (commit),
            .min_i    (adc_min_i[k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]),
            .alarm_o  (alarm_w[k])
        );
    end

    // ---------------- status / read mux ----------------
    always_comb begin
        stat_rd     = rd_req & (rd_addr == ADDR_STATUS);
        // Set beats clear when a new overrun coincides with the status read
        overrun_d   = overrun_set | (overrun_q & ~stat_rd);
        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);

        status_word                                  = '0;
        status_word[STAT_VALID_BIT]                  = valid_q;
        status_word[STAT_OVERRUN_BIT]                = overrun_q;
        status_word[STAT_ALARM_LSB +: CORE_NUM]      = alarm_w;

        rd_mux = '0;
        for (int k = 0; k < CORE_NUM; k++) begin
            if (rd_addr == RD_ADDR_W'(k)) begin
                rd_mux = RD_DATA_W'(snap_q[k]);
            end
        end
        if (rd_addr == ADDR_STATUS) begin
            rd_mux = status_word;
        end else if (rd_addr == ADDR_FRAME) begin
            rd_mux = RD_DATA_W'(frame_cnt_q);
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CORE_NUM; k++) begin
                snap_q[k] <= '0;
            end
            frame_cnt_q <= '0;
            primed_q    <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            overrun_q <= overrun_d;
            rd_ack_q  <= rd_req;
            if (rd_req) begin
                rd_data_q <= rd_mux;
            end
            if (latch_en) begin
                primed_q <= 1'b1;
            end
            if (commit) begin
                for (int k = 0; k < CORE_NUM; k++) begin
                    snap_q[k] <= adc_min_i[k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
                end
                frame_cnt_q <= frame_cnt_d;
                valid_q     <= 1'b1;
            end
        end
    end

    assign rd_ack  = rd_ack_q;
    assign rd_data = rd_data_q;
    assign alarm_o = alarm_w;

endmodule
